mem_stall_ctrl: RTL and testbench
=================================

# mem_stall_ctrl

Parametrised memory-stall freeze controller for the single-cycle CPU. It tracks NCH independent memory channels, such as instruction and data ports. Each channel reports a 3-bit transfer status, and while any channel is mid-transfer the block holds the rest of the CPU frozen. Compared with a single-channel freeze FSM, it adds:
- a one-cycle release margin,
- a stall-length counter,
- a per-channel cause mask,
- an optional stall timeout.

## Interface
Parameters:
- NCH, 2, number of memory channels (1..8)
- CW, 8, stall counter width
- TIMEOUT, 200, HOLD cycles before forced release (only with STALL_TIMEOUT_EN); must be 1..2^CW-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- mem_state  in  3*NCH  channel i status at [3i+2:3i]; 3'b000 FREE, 3'b111 STALL, other codes transient
- hold  out  1  1 = freeze all CPU state; 0 = advance
- release  out  1  one-cycle pulse in the RELEASE state
- hold_src  out  NCH  channels that have been busy since the last RUN
- stall_cnt  out  CW  cycles spent in current/last HOLD episode
- timeout  out  1  sticky forced-release flag

## Operation
- Per-channel busy flag busy[i]:
  - STALL sets it.
  - FREE clears it.
  - A transient code keeps the current value, so a transfer stays frozen through intermediate codes.
- any_next = OR of the next-cycle busy flags.
- Top FSM states are RUN, HOLD and RELEASE.
  - RUN (hold=0): go to HOLD if any_next, else stay in RUN.
  - HOLD (hold=1): go to RELEASE if !any_next, else stay in HOLD.
  - RELEASE (hold=1, release=1): go to HOLD if any_next, else go to RUN.
- stall_cnt:
  - Loads 1 on entry to HOLD.
  - Increments each further HOLD cycle and saturates at 2^CW-1.
  - Holds its value in RELEASE and clears to 0 on entry to RUN.
- hold_src:
  - Each cycle in HOLD or RELEASE it ORs in busy_next.
  - It is loaded with busy_next on the RUN->HOLD transition and cleared on entry to RUN.
- Simultaneous STALL on one channel and FREE on another: the flags update independently. HOLD persists while any flag remains set.
- rst mid-operation: the FSM goes to RUN, and all flags, counters and outputs clear on the next edge regardless of mem_state.

## Timing
- Reset values:
  - state RUN; busy=0
  - hold=0, release=0, hold_src=0, stall_cnt=0, timeout=0
- Outputs are Moore, decoded from registered state only; there is no combinational mem_state->hold path.
- Freeze latency: STALL sampled at edge t gives hold=1 from cycle t+1.
- Release latency: the last FREE sampled at edge t puts RELEASE in cycle t+1 (hold still 1) and RUN in t+2. The pipeline therefore advances two cycles after FREE.
- A STALL arriving while in RELEASE returns the FSM to HOLD with no hold=0 gap. stall_cnt reloads 1 and hold_src keeps accumulating.

## Configuration
- STALL_TIMEOUT_EN defined:
  - When the FSM is in HOLD with stall_cnt == TIMEOUT, the next edge forces RELEASE.
  - That same edge clears all busy flags and sets timeout=1. timeout stays 1 until rst.
  - Timeout takes priority over a STALL sampled on the same edge. That STALL re-enters HOLD from RELEASE on a later edge.
- STALL_TIMEOUT_EN undefined:
  - No forced release.
  - timeout is tied to 0.
  - The TIMEOUT parameter is ignored.

## Structure
- Shared package holds:
  - the status codes MS_FREE=3'b000 and MS_STALL=3'b111
  - the FSM state encoding ST_RUN/ST_HOLD/ST_RELEASE (2 bits)
- One sub-module, mem_chan_track, instanced NCH times: a 1-bit busy flag with FREE/STALL/transient update. Its outputs are busy_q and busy_next.
- The top level holds the FSM, counter, mask and timeout logic.

## Test plan
All scenarios use NCH=2, CW=8, TIMEOUT=4.
- Reset, then hold mem_state=6'b000000: hold=0, stall_cnt=0, hold_src=0 for 10 cycles.
- Ch0 STALL for 3 cycles, then transient 3'b010 for 2 cycles, then FREE: hold=1 from cycle 2 through 1 cycle after FREE, release pulses once, stall_cnt=5, hold_src=2'b01.
- Ch0 STALL, then ch1 STALL while ch0 still busy, then ch0 FREE, then ch1 FREE 3 cycles later: hold stays 1 continuously until RELEASE, hold_src=2'b11.
- FREE followed by STALL on the next cycle (arriving in RELEASE): hold never drops to 0, stall_cnt reloads 1.
- STALL_TIMEOUT_EN, ch1 stuck at STALL: after 4 HOLD cycles RELEASE occurs, timeout=1. The next STALL re-enters HOLD; timeout remains 1 until rst.
- rst asserted mid-HOLD with ch0 STALL: next cycle hold=0, stall_cnt=0, timeout=0. STALL sampled on the first post-reset edge gives hold=1 one cycle later.

Source files
------------

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared constants for the memory-stall freeze controller:
// channel status codes and the top FSM state encoding.
package mem_stall_ctrl_pkg;

    localparam logic [2:0] MS_FREE  = 3'b000;
    localparam logic [2:0] MS_STALL = 3'b111;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/mem_chan_track.sv
// Per-channel busy flag: STALL sets, FREE clears, transient codes keep.
// clr_i drops the flag on a forced release.
module mem_chan_track
    import mem_stall_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_i,
    input  logic       clr_i,
    output logic       busy_q_o,
    output logic       busy_next_o
);

    logic busy_q;
    logic busy_d;

    // Next flag value from this cycle's status code.
    always_comb begin
        busy_d = busy_q;
        case (code_i)
            MS_FREE:  busy_d = 1'b0;
            MS_STALL: busy_d = 1'b1;
            default:  busy_d = busy_q;
        endcase
    end

    // Flag register; a forced release wins over the code.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else if (clr_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_q_o    = busy_q;
    assign busy_next_o = busy_d;

endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-stall freeze controller: RUN/HOLD/RELEASE FSM, stall counter,
// cause mask. Optional HOLD timeout enabled by `define STALL_TIMEOUT_EN.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int CW      = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3*NCH-1:0] mem_state_i,
    output logic             hold_o,
    output logic             release_o,
    output logic [NCH-1:0]   hold_src_o,
    output logic [CW-1:0]    stall_cnt_o,
    output logic             timeout_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("mem_stall_ctrl: NCH out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > (2 ** CW) - 1) begin : g_bad_to
        $error("mem_stall_ctrl: TIMEOUT out of range");
    end

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] src_q, src_d;
    logic [NCH-1:0] busy_q;
    logic [NCH-1:0] busy_next;
    logic           any_next;
    logic           force_rel;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        mem_chan_track u_trk (
            .clk         (clk),
            .rst         (rst),
            .code_i      (mem_state_i[3*i +: 3]),
            .clr_i       (force_rel),
            .busy_q_o    (busy_q[i]),
            .busy_next_o (busy_next[i])
        );
    end

    assign any_next = |busy_next;

`ifdef STALL_TIMEOUT_EN
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    logic timeout_q;

    assign force_rel = (state_q == ST_HOLD) && (cnt_q == TO_CNT);

    // Sticky flag, set on the edge that forces the release.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (force_rel) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next FSM state; a forced release overrides pending stalls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (any_next) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (force_rel || !any_next) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = any_next ? ST_HOLD : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Stall length: 1 on HOLD entry, saturating count, kept in RELEASE.
    always_comb begin
        cnt_d = cnt_q;
        case (state_d)
            ST_HOLD: begin
                if (state_q != ST_HOLD) begin
                    cnt_d = CW'(1);
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: cnt_d = cnt_q;
            default:    cnt_d = '0;
        endcase
    end

    // Cause mask: loaded on leaving RUN, accumulates until RUN again.
    always_comb begin
        src_d = src_q;
        if (state_d == ST_RUN) begin
            src_d = '0;
        end else if (state_q == ST_RUN) begin
            src_d = busy_next;
        end else begin
            src_d = src_q | busy_next;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    // busy_q only feeds back inside the trackers; kept for visibility.
    logic unused_busy;
    assign unused_busy = ^busy_q;

    assign hold_o      = (state_q != ST_RUN);
    assign release_o   = (state_q == ST_RELEASE);
    assign hold_src_o  = src_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl (NCH=2, CW=8, TIMEOUT=4).
// Covers both builds of STALL_TIMEOUT_EN.
module tb_mem_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] mem_state_i;
    logic       hold_o;
    logic       release_o;
    logic [1:0] hold_src_o;
    logic [7:0] stall_cnt_o;
    logic       timeout_o;

    int checks = 0;
    int passes = 0;

`ifdef STALL_TIMEOUT_EN
    localparam logic TO_PRE = 1'b1;
`else
    localparam logic TO_PRE = 1'b0;
`endif

    mem_stall_ctrl #(
        .NCH     (2),
        .CW      (8),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_state_i (mem_state_i),
        .hold_o      (hold_o),
        .release_o   (release_o),
        .hold_src_o  (hold_src_o),
        .stall_cnt_o (stall_cnt_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {hold, release, timeout, hold_src, stall_cnt}.
    function automatic logic [12:0] ex(logic h, logic r, logic t,
                                       logic [1:0] s, logic [7:0] c);
        return {h, r, t, s, c};
    endfunction

    function automatic logic [12:0] obs();
        return {hold_o, release_o, timeout_o, hold_src_o, stall_cnt_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_state_i = 6'o00;
        tick();
        tick();
        checks++;
        if (obs() !== 13'd0)
            $display("FAIL reset: got %b want %b", obs(), 13'd0);
        else passes++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs() !== 13'd0)
                $display("FAIL idle[%0d]: got %b want %b", i, obs(), 13'd0);
            else passes++;
        end
    endtask

    task automatic test_transient();
        logic [5:0]  ms [7];
        logic [12:0] e  [7];
        int pulses;
        ms = '{6'o07, 6'o07, 6'o07, 6'o02, 6'o02, 6'o00, 6'o00};
        e  = '{ex(1,0,0,2'b01,1), ex(1,0,0,2'b01,2), ex(1,0,0,2'b01,3),
               ex(1,0,0,2'b01,4), ex(1,0,0,2'b01,5), ex(1,1,0,2'b01,5),
               ex(0,0,0,2'b00,0)};
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            mem_state_i = ms[i];
            tick();
            if (release_o === 1'b1) pulses++;
            checks++;
            if (obs() !== e[i])
                $display("FAIL transient[%0d]: got %b want %b",
                         i, obs(), e[i]);
            else passes++;
        end
        checks++;
        if (pulses !== 1)
            $display("FAIL transient_pulses: got %0d want 1", pulses);
        else passes++;
    endtask

    task automatic test_two_chan();
        logic [5:0]  ms [7];
        logic [12:0] e  [7];
        ms = '{6'o07, 6'o77, 6'o70, 6'o70, 6'o70, 6'o00, 6'o00};
        e  = '{ex(1,0,0,2'b01,1), ex(1,0,0,2'b11,2), ex(1,0,0,2'b11,3),
               ex(1,0,0,2'b11,4), ex(1,0,0,2'b11,5), ex(1,1,0,2'b11,5),
               ex(0,0,0,2'b00,0)};
        for (int i = 0; i < 7; i++) begin
            mem_state_i = ms[i];
            tick();
            checks++;
            if (obs() !== e[i])
                $display("FAIL two_chan[%0d]: got %b want %b",
                         i, obs(), e[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ms [6];
        logic [12:0] e  [6];
        ms = '{6'o07, 6'o07, 6'o00, 6'o70, 6'o00, 6'o00};
        e  = '{ex(1,0,0,2'b01,1), ex(1,0,0,2'b01,2), ex(1,1,0,2'b01,2),
               ex(1,0,0,2'b11,1), ex(1,1,0,2'b11,1), ex(0,0,0,2'b00,0)};
        for (int i = 0; i < 6; i++) begin
            mem_state_i = ms[i];
            tick();
            checks++;
            if (obs() !== e[i])
                $display("FAIL back_to_back[%0d]: got %b want %b",
                         i, obs(), e[i]);
            else passes++;
        end
    endtask

`ifdef STALL_TIMEOUT_EN
    task automatic test_timeout();
        logic [5:0]  ms [8];
        logic [12:0] e  [8];
        ms = '{6'o70, 6'o70, 6'o70, 6'o70, 6'o70, 6'o70, 6'o00, 6'o00};
        e  = '{ex(1,0,0,2'b10,1), ex(1,0,0,2'b10,2), ex(1,0,0,2'b10,3),
               ex(1,0,0,2'b10,4), ex(1,1,1,2'b10,4), ex(1,0,1,2'b10,1),
               ex(1,1,1,2'b10,1), ex(0,0,1,2'b00,0)};
        for (int i = 0; i < 8; i++) begin
            mem_state_i = ms[i];
            tick();
            checks++;
            if (obs() !== e[i])
                $display("FAIL timeout[%0d]: got %b want %b",
                         i, obs(), e[i]);
            else passes++;
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [5:0]  ms [8];
        logic [12:0] e  [8];
        ms = '{6'o70, 6'o70, 6'o70, 6'o70, 6'o70, 6'o70, 6'o00, 6'o00};
        e  = '{ex(1,0,0,2'b10,1), ex(1,0,0,2'b10,2), ex(1,0,0,2'b10,3),
               ex(1,0,0,2'b10,4), ex(1,0,0,2'b10,5), ex(1,0,0,2'b10,6),
               ex(1,1,0,2'b10,6), ex(0,0,0,2'b00,0)};
        for (int i = 0; i < 8; i++) begin
            mem_state_i = ms[i];
            tick();
            checks++;
            if (obs() !== e[i])
                $display("FAIL no_timeout[%0d]: got %b want %b",
                         i, obs(), e[i]);
            else passes++;
        end
    endtask

    task automatic test_saturate();
        mem_state_i = 6'o07;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k >= 254) begin
                checks++;
                if (obs() !== ex(1,0,0,2'b01,(k > 255) ? 8'd255 : 8'(k)))
                    $display("FAIL saturate[%0d]: got %b", k, obs());
                else passes++;
            end
        end
        mem_state_i = 6'o00;
        tick();
        checks++;
        if (obs() !== ex(1,1,0,2'b01,255))
            $display("FAIL saturate_rel: got %b want %b",
                     obs(), ex(1,1,0,2'b01,255));
        else passes++;
        tick();
        checks++;
        if (obs() !== 13'd0)
            $display("FAIL saturate_run: got %b want %b", obs(), 13'd0);
        else passes++;
    endtask
`endif

    task automatic test_reset_mid();
        mem_state_i = 6'o07;
        tick();
        checks++;
        if (obs() !== ex(1,0,TO_PRE,2'b01,1))
            $display("FAIL rmid_h1: got %b want %b",
                     obs(), ex(1,0,TO_PRE,2'b01,1));
        else passes++;
        tick();
        checks++;
        if (obs() !== ex(1,0,TO_PRE,2'b01,2))
            $display("FAIL rmid_h2: got %b want %b",
                     obs(), ex(1,0,TO_PRE,2'b01,2));
        else passes++;
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== 13'd0)
            $display("FAIL rmid_rst: got %b want %b", obs(), 13'd0);
        else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== ex(1,0,0,2'b01,1))
            $display("FAIL rmid_post: got %b want %b",
                     obs(), ex(1,0,0,2'b01,1));
        else passes++;
        mem_state_i = 6'o00;
        tick();
        checks++;
        if (obs() !== ex(1,1,0,2'b01,1))
            $display("FAIL rmid_rel: got %b want %b",
                     obs(), ex(1,1,0,2'b01,1));
        else passes++;
        tick();
        checks++;
        if (obs() !== 13'd0)
            $display("FAIL rmid_run: got %b want %b", obs(), 13'd0);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        mem_state_i = 6'o00;
        test_reset();
        test_transient();
        test_two_chan();
        test_back_to_back();
`ifdef STALL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
        test_saturate();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
